// File: rtl/gf_syndrome_acc.sv
// Reed-Solomon syndrome accumulator over GF(2^M): Horner evaluation of the
// received polynomial at alpha^1..alpha^NSYN, one symbol per clock, framed by in_first.
module gf_syndrome_acc #(
    parameter int              M    = 3,
    parameter logic [M-1:0]    POLY = 3'b011,
    parameter int              NSYN = 2,
    parameter int              NSYM = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                in_first,
    input  logic [M-1:0]        in_sym,
    output logic                out_valid,
    output logic [NSYN*M-1:0]   out_syn,
    output logic                out_err,
    output logic                frame_err
);

    localparam int CW = $clog2(NSYM + 1);

    // One multiply-by-alpha step: shift left, fold the overflow back through POLY.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY : {M{1'b0}});
    endfunction

    // Constant multiply by alpha^n as a chain of n single steps.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] a, input int n);
        logic [M-1:0] r;
        r = a;
        for (int k = 0; k < n; k++) begin
            r = mul_alpha(r);
        end
        return r;
    endfunction

    logic [CW-1:0]             cnt_r;
    logic [NSYN-1:0][M-1:0]    acc_r;
    logic [NSYN-1:0][M-1:0]    upd_s;
    logic [NSYN*M-1:0]         out_syn_r;
    logic                      out_valid_r;
    logic                      out_err_r;
    logic                      frame_err_r;
    logic                      active_s;
    logic                      last_s;

    // Horner step for every lane; lane j evaluates at alpha^(j+1).
    always_comb begin
        for (int j = 0; j < NSYN; j++) begin
            upd_s[j] = mul_alpha_pow(acc_r[j], j + 1) ^ in_sym;
        end
        active_s = (cnt_r != {CW{1'b0}});
        last_s   = (cnt_r == CW'(NSYM - 1));
    end

    // Framing counter, lane accumulators and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            acc_r       <= '0;
            out_syn_r   <= {(NSYN*M){1'b0}};
            out_valid_r <= 1'b0;
            out_err_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (in_valid) begin
                if (in_first) begin
                    // A restart mid-codeword aborts it without a result.
                    for (int j = 0; j < NSYN; j++) begin
                        acc_r[j] <= in_sym;
                    end
                    cnt_r       <= CW'(1);
                    frame_err_r <= active_s;
                end else if (active_s) begin
                    acc_r <= upd_s;
                    if (last_s) begin
                        out_syn_r   <= upd_s;
                        out_err_r   <= |upd_s;
                        out_valid_r <= 1'b1;
                        cnt_r       <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end else begin
                    frame_err_r <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_syn   = out_syn_r;
    assign out_err   = out_err_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_gf_syndrome_acc.sv
// Cycle-accurate scoreboard bench for gf_syndrome_acc at the default parameters
// (GF(8), x^3+x+1, two syndromes, seven-symbol codewords).
module tb_gf_syndrome_acc;

    typedef struct packed {
        logic       v;
        logic       fe;
        logic       err;
        logic [5:0] syn;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_first;
    logic [2:0] in_sym;
    logic       out_valid;
    logic [5:0] out_syn;
    logic       out_err;
    logic       frame_err;

    int         n_checks;
    int         n_fail;
    exp_t       exp_q[$];

    int         mcnt;
    logic [2:0] mr[7];
    logic [5:0] held_syn;
    logic       held_err;

    gf_syndrome_acc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_sym    (in_sym),
        .out_valid (out_valid),
        .out_syn   (out_syn),
        .out_err   (out_err),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Generic GF(8) product by shift-and-add with reduction by x^3+x+1.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [5:0] p;
        p = 6'd0;
        for (int i = 0; i < 3; i++)
            if (b[i]) p = p ^ ({3'b000, a} << i);
        for (int i = 5; i >= 3; i--)
            if (p[i]) p = p ^ (6'b001011 << (i - 3));
        return p[2:0];
    endfunction

    // Direct evaluation of r(alpha^j) = sum r_i * alpha^(j*deg_i).
    function automatic logic [5:0] syndromes();
        logic [2:0] apow[7];
        logic [2:0] s[2];
        apow = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
        for (int j = 1; j <= 2; j++) begin
            s[j-1] = 3'd0;
            for (int i = 0; i < 7; i++)
                s[j-1] = s[j-1] ^ gf_mul(mr[i], apow[(j * (6 - i)) % 7]);
        end
        return {s[1], s[0]};
    endfunction

    // Drive one cycle of input and queue what the DUT must show after the edge.
    task automatic drive(input logic v, input logic f, input logic [2:0] sym);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_first = f;
        in_sym   = sym;
        e = '0;
        if (v) begin
            if (f) begin
                e.fe  = (mcnt != 0);
                mr[0] = sym;
                mcnt  = 1;
            end else if (mcnt > 0) begin
                mr[mcnt] = sym;
                mcnt++;
                if (mcnt == 7) begin
                    held_syn = syndromes();
                    held_err = |held_syn;
                    e.v  = 1'b1;
                    mcnt = 0;
                end
            end else begin
                e.fe = 1'b1;
            end
        end
        e.syn = held_syn;
        e.err = held_err;
        exp_q.push_back(e);
    endtask

    task automatic send_cw(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                           input logic [2:0] s3, input logic [2:0] s4, input logic [2:0] s5,
                           input logic [2:0] s6, input int max_gap);
        logic [2:0] syms[7];
        syms = '{s0, s1, s2, s3, s4, s5, s6};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, (i == 0), syms[i]);
            if (max_gap > 0 && i < 6) begin
                int g;
                g = $urandom_range(max_gap, 1);
                for (int k = 0; k < g; k++) drive(1'b0, 1'b0, 3'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_syn"},   {26'd0, out_syn},   32'd0);
        check_eq({tag, "_err"},   {31'd0, out_err},   32'd0);
        check_eq({tag, "_fe"},    {31'd0, frame_err}, 32'd0);
    endtask

    // Scoreboard: compare every registered output one step after each driven cycle.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                check_eq("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                check_eq("out_syn",   {26'd0, out_syn},   {26'd0, e.syn});
                check_eq("out_err",   {31'd0, out_err},   {31'd0, e.err});
            end else if (out_valid || frame_err) begin
                check_eq("spurious_pulse", {30'd0, out_valid, frame_err}, 32'd0);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mcnt     = 0;
        held_syn = 6'd0;
        held_err = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_sym   = 3'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // All-zero codeword, then single-symbol patterns, back to back.
        send_cw(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
        drive(1'b0, 1'b0, 3'd0);
        send_cw(3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
        send_cw(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
        repeat (3) drive(1'b0, 1'b0, 3'd0);

        // Degree-1 symbol with idle gaps between symbols.
        send_cw(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3);
        repeat (2) drive(1'b0, 1'b0, 3'd0);

        // Restart at symbol 4, then a clean zero codeword.
        drive(1'b1, 1'b1, 3'd5);
        drive(1'b1, 1'b0, 3'd2);
        drive(1'b1, 1'b0, 3'd7);
        send_cw(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
        drive(1'b0, 1'b0, 3'd0);

        // Stray symbol while idle, then a fresh codeword must be unaffected.
        drive(1'b1, 1'b0, 3'd6);
        drive(1'b0, 1'b0, 3'd0);
        send_cw(3'd4, 3'd1, 3'd7, 3'd2, 3'd0, 3'd3, 3'd6, 0);
        drive(1'b0, 1'b0, 3'd0);

        // Asynchronous reset after three symbols.
        drive(1'b1, 1'b1, 3'd7);
        drive(1'b1, 1'b0, 3'd5);
        drive(1'b1, 1'b0, 3'd1);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mcnt     = 0;
        held_syn = 6'd0;
        held_err = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        check_reset_outputs("midreset2");
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd0);
        send_cw(3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd1, 0);

        // Random codewords, back to back and with gaps.
        for (int n = 0; n < 6; n++) begin
            send_cw(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
                    3'($urandom_range(7, 0)), (n % 2) * 2);
        end
        repeat (4) drive(1'b0, 1'b0, 3'd0);
        @(posedge clk);
        #2;
        check_eq("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
